// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: control, ROM and status bundle between a controller and the fetch sequencer
interface fetch_sequencer_if #(
  parameter int IW = 13,
  parameter int DW = 9,
  parameter int OW = 8,
  parameter int CW = 16
);
  logic          Start;
  logic [IW-1:0] StartAddr;
  logic          Halt;
  logic          Stall;
  logic          BranchAbs;
  logic          BranchRel;
  logic [IW-1:0] Target;
  logic [OW-1:0] Offset;
  logic [DW-1:0] InstIn;
  logic [IW-1:0] InstAddress;
  logic [DW-1:0] InstOut;
  logic          InstValid;
  logic          Done;
  logic          Overrun;
  logic [CW-1:0] CycleCount;
  modport master (
    output Start, StartAddr, Halt, Stall, BranchAbs, BranchRel, Target, Offset, InstIn,
    input  InstAddress, InstOut, InstValid, Done, Overrun, CycleCount
  );
  modport slave (
    input  Start, StartAddr, Halt, Stall, BranchAbs, BranchRel, Target, Offset, InstIn,
    output InstAddress, InstOut, InstValid, Done, Overrun, CycleCount
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program counter, branch/stall handling and IDLE/RUN/DONE fetch control
module fetch_sequencer #(
  parameter int IW = 13,
  parameter int DW = 9,
  parameter int OW = 8,
  parameter int CW = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  fetch_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t        state_q, state_d;
  logic [IW-1:0] pc_q, pc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovr_q, ovr_d;
  logic          valid_q, done_q;
  logic [IW-1:0] rel_off;
  assign rel_off = {{(IW-OW){bus.Offset[OW-1]}}, bus.Offset};
  // next-state: start reload outside RUN, Halt > Stall > BranchAbs > BranchRel > increment in RUN
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    ovr_d   = ovr_q;
    if (state_q == RUN) begin
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
      if (bus.Halt) begin
        state_d = DONE;
      end else if (!bus.Stall) begin
        if (bus.BranchAbs) begin
          pc_d = bus.Target;
        end else if (bus.BranchRel) begin
          pc_d = pc_q + rel_off;
        end else begin
          pc_d  = pc_q + IW'(1);
          ovr_d = ovr_q | (pc_q == '1);
        end
      end
    end else if (bus.Start) begin
      state_d = RUN;
      pc_d    = bus.StartAddr;
      cnt_d   = '0;
      ovr_d   = 1'b0;
    end
  end
  // state and registered status outputs, cleared asynchronously on reset
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
      valid_q <= (state_d == RUN);
      done_q  <= (state_d == DONE);
    end
  end
  assign bus.InstAddress = pc_q;
  assign bus.InstOut     = valid_q ? bus.InstIn : DW'(0);
  assign bus.InstValid   = valid_q;
  assign bus.Done        = done_q;
  assign bus.Overrun     = ovr_q;
  assign bus.CycleCount  = cnt_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed stimulus, cycle-by-cycle model compare and literal spot checks
module tb_fetch_sequencer;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  fetch_sequencer_if #(.CW(16)) ifa ();
  fetch_sequencer_if #(.CW(4))  ifb ();
  fetch_sequencer #(.CW(16)) ua (.Clk(Clk), .Reset(Reset), .bus(ifa));
  fetch_sequencer #(.CW(4))  ub (.Clk(Clk), .Reset(Reset), .bus(ifb));
  always #5 Clk = ~Clk;
  function automatic logic [8:0] rom_f(logic [12:0] a);
    return a[8:0] ^ {a[12:9], 5'b10101};
  endfunction
  assign ifa.InstIn    = rom_f(ifa.InstAddress);
  assign ifb.InstIn    = rom_f(ifb.InstAddress);
  assign ifb.Start     = ifa.Start;
  assign ifb.StartAddr = ifa.StartAddr;
  assign ifb.Halt      = ifa.Halt;
  assign ifb.Stall     = ifa.Stall;
  assign ifb.BranchAbs = ifa.BranchAbs;
  assign ifb.BranchRel = ifa.BranchRel;
  assign ifb.Target    = ifa.Target;
  assign ifb.Offset    = ifa.Offset;
  task automatic chk(string n, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  // behavioural model: 0=IDLE 1=RUN 2=DONE, plain integer arithmetic on the PC
  int m_st, m_pc, m_c16, m_c4;
  bit m_ov;
  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_st <= 0; m_pc <= 0; m_c16 <= 0; m_c4 <= 0; m_ov <= 0;
    end else if (m_st == 1) begin
      m_c16 <= (m_c16 < 65535) ? m_c16 + 1 : 65535;
      m_c4  <= (m_c4 < 15) ? m_c4 + 1 : 15;
      if (ifa.Halt) m_st <= 2;
      else if (!ifa.Stall) begin
        if (ifa.BranchAbs) m_pc <= int'(ifa.Target);
        else if (ifa.BranchRel) m_pc <= (m_pc + int'($signed(ifa.Offset)) + 8192) % 8192;
        else begin
          m_pc <= (m_pc + 1) % 8192;
          if (m_pc == 8191) m_ov <= 1;
        end
      end
    end else if (ifa.Start) begin
      m_st <= 1; m_pc <= int'(ifa.StartAddr); m_c16 <= 0; m_c4 <= 0; m_ov <= 0;
    end
  end
  // every-cycle compare of both instances against the model
  always @(negedge Clk) begin
    chk("addr", int'(ifa.InstAddress), m_pc);
    chk("valid", int'(ifa.InstValid), int'(m_st == 1));
    chk("done", int'(ifa.Done), int'(m_st == 2));
    chk("overrun", int'(ifa.Overrun), int'(m_ov));
    chk("count", int'(ifa.CycleCount), m_c16);
    chk("instout", int'(ifa.InstOut), (m_st == 1) ? int'(rom_f(13'(m_pc))) : 0);
    chk("b_addr", int'(ifb.InstAddress), m_pc);
    chk("b_count", int'(ifb.CycleCount), m_c4);
  end
  task automatic step();
    @(posedge Clk);
    #1;
  endtask
  initial begin
    ifa.Start = 0; ifa.StartAddr = '0; ifa.Halt = 0; ifa.Stall = 0;
    ifa.BranchAbs = 0; ifa.BranchRel = 0; ifa.Target = '0; ifa.Offset = '0;
    step(); step();
    Reset = 0;
    chk("rst_addr", int'(ifa.InstAddress), 0);
    chk("rst_valid", int'(ifa.InstValid), 0);
    chk("rst_done", int'(ifa.Done), 0);
    chk("rst_instout", int'(ifa.InstOut), 0);
    step();
    chk("idle_hold", int'(ifa.InstValid), 0);
    ifa.Start = 1; ifa.StartAddr = 13'h010;
    step(); ifa.Start = 0;
    chk("seq0", int'(ifa.InstAddress), 'h010);
    chk("seq0_valid", int'(ifa.InstValid), 1);
    chk("seq0_inst", int'(ifa.InstOut), int'(rom_f(13'h010)));
    step(); chk("seq1", int'(ifa.InstAddress), 'h011);
    step(); chk("seq2", int'(ifa.InstAddress), 'h012);
    ifa.Halt = 1;
    step(); ifa.Halt = 0;
    chk("halt_done", int'(ifa.Done), 1);
    chk("halt_valid", int'(ifa.InstValid), 0);
    chk("halt_count", int'(ifa.CycleCount), 3);
    ifa.Start = 1; ifa.StartAddr = 13'h020;
    step(); ifa.Start = 0;
    chk("restart_addr", int'(ifa.InstAddress), 'h020);
    chk("restart_count", int'(ifa.CycleCount), 0);
    ifa.BranchRel = 1; ifa.Offset = 8'hFC;
    step(); ifa.BranchRel = 0;
    chk("rel_back", int'(ifa.InstAddress), 'h01C);
    ifa.BranchAbs = 1; ifa.Target = 13'h1ABC;
    step();
    chk("abs", int'(ifa.InstAddress), 'h1ABC);
    ifa.Target = 13'h000;
    step(); ifa.BranchAbs = 0;
    chk("abs_zero", int'(ifa.InstAddress), 0);
    ifa.BranchRel = 1; ifa.Offset = 8'hFF;
    step(); ifa.BranchRel = 0;
    chk("rel_wrap", int'(ifa.InstAddress), 'h1FFF);
    chk("rel_wrap_ovr", int'(ifa.Overrun), 0);
    step();
    chk("seq_wrap", int'(ifa.InstAddress), 0);
    chk("seq_wrap_ovr", int'(ifa.Overrun), 1);
    ifa.Halt = 1; step(); ifa.Halt = 0;
    ifa.Start = 1; ifa.StartAddr = 13'h1FFE;
    step(); ifa.Start = 0;
    chk("w0", int'(ifa.InstAddress), 'h1FFE);
    chk("w0_ovr", int'(ifa.Overrun), 0);
    step(); chk("w1", int'(ifa.InstAddress), 'h1FFF);
    chk("w1_ovr", int'(ifa.Overrun), 0);
    step(); chk("w2", int'(ifa.InstAddress), 0);
    chk("w2_ovr", int'(ifa.Overrun), 1);
    ifa.Halt = 1; step(); ifa.Halt = 0;
    chk("done_frozen_ovr", int'(ifa.Overrun), 1);
    ifa.Start = 1; ifa.StartAddr = 13'h100;
    step(); ifa.Start = 0;
    chk("s100_addr", int'(ifa.InstAddress), 'h100);
    chk("s100_ovr", int'(ifa.Overrun), 0);
    chk("s100_count", int'(ifa.CycleCount), 0);
    for (int i = 0; i < 20; i++) step();
    chk("sat_addr", int'(ifa.InstAddress), 'h114);
    chk("sat_a", int'(ifa.CycleCount), 20);
    chk("sat_b", int'(ifb.CycleCount), 15);
    ifa.Halt = 1; step(); ifa.Halt = 0;
    chk("sat_b_done", int'(ifb.CycleCount), 15);
    ifa.Start = 1; ifa.StartAddr = 13'h005;
    step(); ifa.Start = 0;
    ifa.Stall = 1;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("stall_addr", int'(ifa.InstAddress), 'h005);
      chk("stall_count", int'(ifa.CycleCount), i);
      chk("stall_valid", int'(ifa.InstValid), 1);
    end
    ifa.Stall = 0;
    step(); chk("post_stall", int'(ifa.InstAddress), 'h006);
    ifa.Stall = 1; ifa.BranchAbs = 1; ifa.Target = 13'h100;
    step(); ifa.Stall = 0; ifa.BranchAbs = 0;
    chk("stall_abs", int'(ifa.InstAddress), 'h006);
    ifa.Start = 1; ifa.StartAddr = 13'h300;
    step(); ifa.Start = 0;
    chk("start_in_run", int'(ifa.InstAddress), 'h007);
    chk("start_in_run_cnt", int'(ifa.CycleCount), 7);
    ifa.Halt = 1; ifa.Stall = 1;
    step(); ifa.Halt = 0; ifa.Stall = 0;
    chk("halt_stall_done", int'(ifa.Done), 1);
    chk("halt_stall_addr", int'(ifa.InstAddress), 'h007);
    chk("halt_stall_cnt", int'(ifa.CycleCount), 8);
    ifa.Start = 1; ifa.StartAddr = 13'h040;
    step(); ifa.Start = 0;
    step();
    @(posedge Clk); #3;
    Reset = 1;
    #1;
    chk("arst_addr", int'(ifa.InstAddress), 0);
    chk("arst_valid", int'(ifa.InstValid), 0);
    chk("arst_done", int'(ifa.Done), 0);
    chk("arst_count", int'(ifa.CycleCount), 0);
    step(); step();
    Reset = 0;
    step();
    chk("idle_after_rst", int'(ifa.InstValid), 0);
    ifa.Start = 1; ifa.StartAddr = 13'h040;
    step(); ifa.Start = 0;
    chk("start_after_rst", int'(ifa.InstAddress), 'h040);
    chk("start_after_rst_v", int'(ifa.InstValid), 1);
    ifa.Halt = 1; step(); ifa.Halt = 0;
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Program-counter and fetch controller for the instruction ROM (13-bit address, 9-bit machine code). It owns the address pointer into the ROM and steps it sequentially. It applies absolute and relative branches and stalls from the decoder/ALU, and runs a start/run/done state machine with a saturating cycle counter for program-completion reporting to the testbench.

## Interface
Parameters:
- IW, 13, program counter / ROM address width
- DW, 9, machine code width
- OW, 8, relative branch offset width (two's complement)
- CW, 16, cycle counter width

Ports:
- Clk  input  1  system clock, rising-edge
- Reset  input  1  asynchronous, active-high reset
- Start  input  1  begin execution at StartAddr; honored in IDLE and DONE only
- StartAddr  input  IW  first instruction address
- Halt  input  1  decoder saw the halt instruction
- Stall  input  1  hold the PC this cycle
- BranchAbs  input  1  take absolute jump to Target
- BranchRel  input  1  take relative jump by Offset
- Target  input  IW  absolute jump address
- Offset  input  OW  signed relative displacement, applied to the current PC
- InstIn  input  DW  ROM data for InstAddress (combinational ROM)
- InstAddress  output  IW  ROM address, equal to the PC register
- InstOut  output  DW  InstIn when InstValid, else 0
- InstValid  output  1  high while state is RUN
- Done  output  1  high while state is DONE
- Overrun  output  1  sticky: a sequential increment wrapped from 2^IW-1 to 0
- CycleCount  output  CW  cycles spent in RUN, saturating

## Operation
- States are IDLE, RUN and DONE. The state is encoded in registers; the outputs decode from the state.
- Reset (async) forces the following:
  - state=IDLE, PC=0, CycleCount=0, Overrun=0
  - hence InstAddress=0, InstValid=0, InstOut=0, Done=0
- IDLE:
  - Start=1: PC<=StartAddr, CycleCount<=0, Overrun<=0, go to RUN.
  - Otherwise hold all registers.
- RUN: CycleCount<=CycleCount+1 every cycle, saturating at 2^CW-1 with no wrap. Next-PC priority, highest first:
  - Halt: PC held, go to DONE.
  - Stall: PC held.
  - BranchAbs: PC<=Target.
  - BranchRel: PC<=PC+sign_extend(Offset), modulo 2^IW.
  - Else: PC<=PC+1, modulo 2^IW. If PC was 2^IW-1, set Overrun<=1.
- Branch wrap-around never sets Overrun. Only the sequential increment does.
- Start during RUN is ignored.
- Simultaneous controls resolve strictly by the priority above. Example: Halt+BranchAbs halts with PC unchanged.
- DONE:
  - PC, CycleCount and Overrun are frozen.
  - Start=1 behaves exactly as in IDLE: reload StartAddr, clear the counter and Overrun, enter RUN.
- Reset mid-RUN aborts immediately. No partial update survives.

## Timing
- All control inputs are sampled on the rising edge of Clk.
- The PC updates on that edge. InstAddress reflects the new PC in the following cycle.
- InstOut is combinational from InstIn. The instruction for the current PC is available in the same cycle.
- Start to first valid fetch: 1 cycle. In the cycle after the Start edge, InstValid=1 and InstAddress=StartAddr.
- Branch latency: 1 cycle. The Target/PC+Offset address is presented on the cycle after the branch is sampled, so there is no delay slot.
- Halt: Done=1 and InstValid=0 from the cycle after Halt is sampled. The Halt cycle itself is counted in CycleCount.
- Stall: the same InstAddress is presented again next cycle, and InstValid stays 1.

## Test plan
- Reset then Start with StartAddr=0x010 → InstAddress sequence 0x010,0x011,0x012 on successive cycles with InstValid=1. After Halt is asserted on the 3rd RUN cycle, Done=1 and CycleCount=3.
- At PC=0x020: BranchRel with Offset=0xFC → next InstAddress=0x01C. At PC=0x01C: BranchAbs with Target=0x1ABC → next InstAddress=0x1ABC. At PC=0x000: BranchRel with Offset=0xFF → 0x1FFF with Overrun still 0.
- StartAddr=0x1FFE, run 3 cycles → InstAddress 0x1FFE,0x1FFF,0x0000, and Overrun=1 from the cycle showing 0x0000.
- Stall for 4 cycles at PC=0x005 → InstAddress stays 0x005 for 5 cycles total and CycleCount still increments each cycle. Stall+BranchAbs together → PC held. Halt+Stall together → DONE.
- Assert Reset asynchronously mid-RUN (between clock edges) → InstAddress=0, Done=0, InstValid=0 immediately. After Reset releases, the state is IDLE and Start works normally.
- Saturation and restart:
  - With CW forced to 4, run 20 cycles → CycleCount sticks at 15.
  - In DONE, Start with StartAddr=0x100 → counter 0, Overrun 0, InstAddress=0x100 next cycle.
  - Start pulsed during RUN → no effect.
